// File: rtl/alu_word_sequencer.sv
// alu_word_sequencer: runs one multi-word operation on a SIZE-bit ALU, one
// word per clock, chaining carry/borrow/shift bits between words. Commands
// arrive on a valid/ready interface; the wide result, final carry and zero
// flag leave on a valid/ready response interface.
module alu_word_sequencer #(
   parameter int SIZE  = 8,
   parameter int WORDS = 4,
   localparam int LW   = $clog2(WORDS),
   localparam int W    = WORDS * SIZE
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [3:0]      cmd_op,
   input  logic [LW-1:0]   cmd_len,
   input  logic [W-1:0]    cmd_a,
   input  logic [W-1:0]    cmd_b,
   input  logic            cmd_cin,
   output logic            alu_ce,
   output logic [3:0]      alu_op,
   output logic [SIZE-1:0] alu_left,
   output logic [SIZE-1:0] alu_right,
   output logic            alu_cin,
   input  logic [SIZE-1:0] alu_out,
   input  logic            alu_cout,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [W-1:0]    rsp_result,
   output logic            rsp_carry,
   output logic            rsp_zero,
   output logic            rsp_illegal
);

   // ALU opcode encoding; codes at or above OP_HLT are control/undefined
   localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_INC = 4'd2,  OP_DEC = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR = 4'd6,  OP_NOT = 4'd7;
   localparam logic [3:0] OP_SHL = 4'd8,  OP_SHR = 4'd9,  OP_LD  = 4'd10, OP_ST  = 4'd11;
   localparam logic [3:0] OP_HLT = 4'd12;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t          state_reg;
   logic [3:0]      op_reg;
   logic [LW-1:0]   len_reg;
   logic [LW-1:0]   idx_reg;
   logic [W-1:0]    a_reg;
   logic [W-1:0]    b_reg;
   logic            chain_reg;
   logic            cmd_ready_reg;
   logic            rsp_valid_reg;
   logic [W-1:0]    rsp_result_reg;
   logic            rsp_carry_reg;
   logic            rsp_zero_reg;
   logic            rsp_illegal_reg;

   logic [3:0]      word_op;
   logic [SIZE-1:0] word_left;
   logic [SIZE-1:0] word_right;
   logic            word_cin;
   logic [SIZE-1:0] word_result;
   logic            chain_next;
   logic [W-1:0]    result_next;
   logic            last_word;
   logic            exec_active;
   int              word_base;

   assign exec_active = (state_reg == EXEC);
   assign word_base   = int'(idx_reg) * SIZE;
   assign word_left   = a_reg[word_base +: SIZE];
   assign last_word   = (op_reg == OP_SHR) ? (idx_reg == '0) : (idx_reg == len_reg);

   // Per-word ALU opcode, right operand and carry-in from the latched command
   always_comb begin
      word_op    = op_reg;
      word_right = b_reg[word_base +: SIZE];
      word_cin   = 1'b0;
      case (op_reg)
         OP_ADD, OP_SUB: word_cin = chain_reg;
         OP_INC, OP_DEC: begin
            // upper words propagate the carry/borrow of the increment
            word_right = '0;
            if (idx_reg != '0) begin
               word_op  = (op_reg == OP_INC) ? OP_ADD : OP_SUB;
               word_cin = chain_reg;
            end
         end
         OP_SHL, OP_SHR: word_right = '0;
         default: ;
      endcase
   end

   // Merge the ALU word with the chained bit and compute the next chain value
   always_comb begin
      word_result = alu_out;
      chain_next  = chain_reg;
      case (op_reg)
         OP_SHL: begin
            word_result = {alu_out[SIZE-1:1], chain_reg};
            chain_next  = alu_cout;
         end
         OP_SHR: begin
            word_result = {chain_reg, alu_out[SIZE-2:0]};
            chain_next  = alu_cout;
         end
         OP_ADD, OP_SUB, OP_INC, OP_DEC: chain_next = alu_cout;
         default: ;
      endcase
      result_next = rsp_result_reg;
      result_next[word_base +: SIZE] = word_result;
   end

   // ALU drive is only active during EXEC and is otherwise held at zero
   assign alu_ce    = exec_active;
   assign alu_op    = exec_active ? word_op    : '0;
   assign alu_left  = exec_active ? word_left  : '0;
   assign alu_right = exec_active ? word_right : '0;
   assign alu_cin   = exec_active ? word_cin   : 1'b0;

   assign cmd_ready   = cmd_ready_reg;
   assign rsp_valid   = rsp_valid_reg;
   assign rsp_result  = rsp_result_reg;
   assign rsp_carry   = rsp_carry_reg;
   assign rsp_zero    = rsp_zero_reg;
   assign rsp_illegal = rsp_illegal_reg;

   // Sequencer FSM: accept command, step through words, hold response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         op_reg          <= '0;
         len_reg         <= '0;
         idx_reg         <= '0;
         a_reg           <= '0;
         b_reg           <= '0;
         chain_reg       <= 1'b0;
         cmd_ready_reg   <= 1'b1;
         rsp_valid_reg   <= 1'b0;
         rsp_result_reg  <= '0;
         rsp_carry_reg   <= 1'b0;
         rsp_zero_reg    <= 1'b0;
         rsp_illegal_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (cmd_valid) begin
                  op_reg          <= cmd_op;
                  len_reg         <= cmd_len;
                  a_reg           <= cmd_a;
                  b_reg           <= cmd_b;
                  chain_reg       <= ((cmd_op == OP_ADD) || (cmd_op == OP_SUB)) ? cmd_cin : 1'b0;
                  idx_reg         <= (cmd_op == OP_SHR) ? cmd_len : '0;
                  rsp_result_reg  <= '0;
                  rsp_carry_reg   <= 1'b0;
                  rsp_zero_reg    <= 1'b0;
                  cmd_ready_reg   <= 1'b0;
                  if (cmd_op >= OP_HLT) begin
                     state_reg       <= DONE;
                     rsp_valid_reg   <= 1'b1;
                     rsp_illegal_reg <= 1'b1;
                  end else begin
                     state_reg       <= EXEC;
                     rsp_illegal_reg <= 1'b0;
                  end
               end
            end
            EXEC: begin
               rsp_result_reg <= result_next;
               chain_reg      <= chain_next;
               if (last_word) begin
                  state_reg     <= DONE;
                  rsp_valid_reg <= 1'b1;
                  rsp_carry_reg <= chain_next;
                  rsp_zero_reg  <= ~|result_next;
               end else if (op_reg == OP_SHR) begin
                  idx_reg <= idx_reg - 1'b1;
               end else begin
                  idx_reg <= idx_reg + 1'b1;
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  state_reg     <= IDLE;
                  rsp_valid_reg <= 1'b0;
                  cmd_ready_reg <= 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Directed testbench for alu_word_sequencer with a behavioural 8-bit ALU.
module tb_alu_word_sequencer;

   localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_INC = 4'd2,  OP_DEC = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR = 4'd6,  OP_NOT = 4'd7;
   localparam logic [3:0] OP_SHL = 4'd8,  OP_SHR = 4'd9,  OP_LD  = 4'd10, OP_ST  = 4'd11;
   localparam logic [3:0] OP_HLT = 4'd12, OP_NOP = 4'd15;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_op;
   logic [1:0]  cmd_len;
   logic [31:0] cmd_a;
   logic [31:0] cmd_b;
   logic        cmd_cin;
   logic        alu_ce;
   logic [3:0]  alu_op;
   logic [7:0]  alu_left;
   logic [7:0]  alu_right;
   logic        alu_cin;
   logic [7:0]  alu_out;
   logic        alu_cout;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic        rsp_carry;
   logic        rsp_zero;
   logic        rsp_illegal;

   int checks   = 0;
   int failures = 0;
   int ce_total = 0;
   logic [7:0] left_hist [0:255];

   alu_word_sequencer #(.SIZE(8), .WORDS(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
      .alu_ce(alu_ce), .alu_op(alu_op), .alu_left(alu_left), .alu_right(alu_right),
      .alu_cin(alu_cin), .alu_out(alu_out), .alu_cout(alu_cout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: carry_out is carry (add), borrow (sub) or shifted-out bit
   always_comb begin
      logic [8:0] t;
      t        = 9'd0;
      alu_out  = 8'd0;
      alu_cout = 1'b0;
      case (alu_op)
         OP_ADD: begin t = {1'b0, alu_left} + {1'b0, alu_right} + {8'd0, alu_cin}; alu_out = t[7:0]; alu_cout = t[8]; end
         OP_SUB: begin t = {1'b0, alu_left} - {1'b0, alu_right} - {8'd0, alu_cin}; alu_out = t[7:0]; alu_cout = t[8]; end
         OP_INC: begin t = {1'b0, alu_left} + 9'd1; alu_out = t[7:0]; alu_cout = t[8]; end
         OP_DEC: begin t = {1'b0, alu_left} - 9'd1; alu_out = t[7:0]; alu_cout = t[8]; end
         OP_AND: alu_out = alu_left & alu_right;
         OP_OR:  alu_out = alu_left | alu_right;
         OP_XOR: alu_out = alu_left ^ alu_right;
         OP_NOT: alu_out = ~alu_left;
         OP_SHL: begin alu_out = {alu_left[6:0], 1'b0}; alu_cout = alu_left[7]; end
         OP_SHR: begin alu_out = {1'b0, alu_left[7:1]}; alu_cout = alu_left[0]; end
         OP_LD, OP_ST: alu_out = alu_left;
         default: ;
      endcase
   end

   // Record every ALU-enabled cycle and the left operand driven in it
   always @(negedge clk) begin
      if (alu_ce) begin
         left_hist[ce_total[7:0]] = alu_left;
         ce_total = ce_total + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Offer a command at posedge+1; returns at accept edge + 1
   task automatic send_cmd(input string tag, input logic [3:0] op, input logic [1:0] len,
                           input logic [31:0] a, input logic [31:0] b, input logic cin);
      cmd_op = op; cmd_len = len; cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_valid = 1'b1;
      check({tag, "_ready_pre"}, 64'(cmd_ready), 64'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check({tag, "_ready_busy"}, 64'(cmd_ready), 64'd0);
   endtask

   // Count edges from accept edge (=1) until rsp_valid, bounded
   task automatic wait_rsp(input string tag, input int exp_lat);
      int n;
      n = 1;
      while (!rsp_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_latency"}, 64'(n), 64'(exp_lat));
   endtask

   task automatic handshake(input string tag);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check({tag, "_valid_clr"}, 64'(rsp_valid), 64'd0);
   endtask

   task automatic run(input string tag, input logic [3:0] op, input logic [1:0] len,
                      input logic [31:0] a, input logic [31:0] b, input logic cin,
                      input logic [31:0] er, input logic ec, input logic ez, input logic eil,
                      input int elat, input int ece);
      int ce0;
      ce0 = ce_total;
      send_cmd(tag, op, len, a, b, cin);
      wait_rsp(tag, elat);
      check({tag, "_result"},  64'(rsp_result),  64'(er));
      check({tag, "_carry"},   64'(rsp_carry),   64'(ec));
      check({tag, "_zero"},    64'(rsp_zero),    64'(ez));
      check({tag, "_illegal"}, 64'(rsp_illegal), 64'(eil));
      check({tag, "_ce_cycles"}, 64'(ce_total - ce0), 64'(ece));
      $display("txn %s op=%0d len=%0d a=0x%08h b=0x%08h -> result=0x%08h carry=%0b zero=%0b illegal=%0b",
               tag, op, len, a, b, rsp_result, rsp_carry, rsp_zero, rsp_illegal);
      handshake(tag);
   endtask

   initial begin
      int base;
      logic seen_valid;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_len = 2'd0;
      cmd_a = 32'd0; cmd_b = 32'd0; cmd_cin = 1'b0; rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_cmd_ready",  64'(cmd_ready),  64'd1);
      check("rst_rsp_valid",  64'(rsp_valid),  64'd0);
      check("rst_rsp_result", 64'(rsp_result), 64'd0);
      check("rst_alu_ce",     64'(alu_ce),     64'd0);
      check("rst_alu_op",     64'(alu_op),     64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run("add",  OP_ADD, 2'd3, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0, 5, 4);
      run("sub",  OP_SUB, 2'd1, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b1, 1'b0, 1'b0, 3, 2);
      run("addc", OP_ADD, 2'd0, 32'h0000_00FF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 2, 1);
      run("dec",  OP_DEC, 2'd3, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 5, 4);
      run("inc",  OP_INC, 2'd3, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 5, 4);
      run("and",  OP_AND, 2'd3, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b1, 32'h00F0_1200, 1'b0, 1'b0, 1'b0, 5, 4);
      run("shl",  OP_SHL, 2'd3, 32'h8000_0080, 32'h0000_0000, 1'b0, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 5, 4);
      base = ce_total;
      run("shr",  OP_SHR, 2'd3, 32'h8000_0101, 32'h0000_0000, 1'b0, 32'h4000_0080, 1'b1, 1'b0, 1'b0, 5, 4);
      check("shr_left0", 64'(left_hist[8'(base)]),     64'h80);
      check("shr_left1", 64'(left_hist[8'(base + 1)]), 64'h00);
      check("shr_left2", 64'(left_hist[8'(base + 2)]), 64'h01);
      check("shr_left3", 64'(left_hist[8'(base + 3)]), 64'h01);
      run("nop",  OP_NOP, 2'd3, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1, 0);
      run("hlt",  OP_HLT, 2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1, 0);

      // XOR with the response held back while a new command waits
      send_cmd("xor", OP_XOR, 2'd0, 32'h0000_005A, 32'h0000_005A, 1'b0);
      wait_rsp("xor", 2);
      cmd_op = OP_ADD; cmd_len = 2'd0; cmd_a = 32'd1; cmd_b = 32'd1; cmd_cin = 1'b0; cmd_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("xor_hold_valid",  64'(rsp_valid),  64'd1);
         check("xor_hold_result", 64'(rsp_result), 64'd0);
         check("xor_hold_zero",   64'(rsp_zero),   64'd1);
         check("xor_hold_carry",  64'(rsp_carry),  64'd0);
         check("xor_hold_ready",  64'(cmd_ready),  64'd0);
         @(posedge clk); #1;
      end
      $display("txn xor op=%0d len=0 -> result=0x%08h carry=%0b zero=%0b", OP_XOR, rsp_result, rsp_carry, rsp_zero);
      handshake("xor");
      check("xor_ready_after", 64'(cmd_ready), 64'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("queued_accepted", 64'(cmd_ready), 64'd0);
      wait_rsp("queued", 2);
      check("queued_result", 64'(rsp_result), 64'd2);
      $display("txn queued op=%0d len=0 -> result=0x%08h", OP_ADD, rsp_result);
      handshake("queued");

      // Reset pulse during the second EXEC cycle aborts silently
      send_cmd("abort", OP_ADD, 2'd3, 32'h00FF_FFFF, 32'h0000_0001, 1'b0);
      @(posedge clk); #2;
      check("abort_in_exec", 64'(alu_ce), 64'd1);
      rst_n = 1'b0;
      #1;
      check("abort_cmd_ready",  64'(cmd_ready),  64'd1);
      check("abort_alu_ce",     64'(alu_ce),     64'd0);
      check("abort_alu_left",   64'(alu_left),   64'd0);
      check("abort_rsp_valid",  64'(rsp_valid),  64'd0);
      check("abort_rsp_result", 64'(rsp_result), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         seen_valid = seen_valid | rsp_valid;
      end
      check("abort_no_rsp", 64'(seen_valid), 64'd0);
      $display("txn abort op=%0d len=3 -> aborted by reset", OP_ADD);
      run("post_rst", OP_ADD, 2'd0, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 2, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute time guard so the run always terminates
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
